// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run sequencer: state encoding, the Ack opcode and counter defaults.
// The optional watchdog in run_sequencer is enabled with SEQ_WATCHDOG_EN.
package run_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      MEM   = 3'd3,
      WB    = 3'd4,
      HALT  = 3'd5
   } seq_state_t;

   localparam logic [8:0] kAckInstr  = 9'h1FF;
   localparam int         kCycW      = 16;
   localparam int         kWaitW     = 4;

   // States in which an instruction is in flight.
   function automatic logic is_busy_state(input seq_state_t s);
      return (s == FETCH) || (s == EXEC) || (s == MEM) || (s == WB);
   endfunction

   // States that accept a new Start.
   function automatic logic is_rest_state(input seq_state_t s);
      return (s == IDLE) || (s == HALT);
   endfunction

endpackage

// File: rtl/run_sequencer_mem.sv
// Loadable down-counter that times the data_mem access phase of a load/store.
// expire is high in the last MEM cycle so the sequencer can move to WB on that edge.
module seq_mem_wait
   import run_sequencer_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam logic [kWaitW-1:0] kLoadVal = kWaitW'(MEM_LAT);
   localparam logic [kWaitW-1:0] kOne     = kWaitW'(1);

   logic [kWaitW-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= kLoadVal;
      end else if (en && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - kOne;
      end
   end

   assign expire = en && (cnt_reg == kOne);

endmodule

// File: rtl/run_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB run controller with single-cycle write strobes and run counters.
// Define SEQ_WATCHDOG_EN to add the cycle-budget watchdog (WDOG_LIMIT) and the Timeout flag.
module run_sequencer
   import run_sequencer_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int CYC_W   = kCycW
`ifdef SEQ_WATCHDOG_EN
   ,
   parameter logic [CYC_W-1:0] WDOG_LIMIT = CYC_W'(16'hFFF0)
`endif
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             DecRegWr,
   input  logic             DecMemWr,
   input  logic             DecLoad,
   input  logic             DecAck,
   output logic             PCReset,
   output logic             PCEn,
   output logic             IrLoad,
   output logic             RegWrEn,
   output logic             MemWrEn,
   output logic             Busy,
   output logic             Done,
   output logic             Timeout,
   output logic [CYC_W-1:0] CycleCount,
   output logic [CYC_W-1:0] InstCount
);

   localparam logic [CYC_W-1:0] kCntOne = CYC_W'(1);

   seq_state_t       state_reg;
   logic             irload_reg;
   logic             pcen_reg;
   logic             regwr_reg;
   logic             memwr_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [CYC_W-1:0] cycle_reg;
   logic [CYC_W-1:0] inst_reg;

   logic start_ok;
   logic mem_load;
   logic mem_expire;
   logic wdog_fire;

   function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
      return (&v) ? v : v + kCntOne;
   endfunction

   assign start_ok = Start && is_rest_state(state_reg);
   assign mem_load = (state_reg == EXEC) && !DecAck && (DecLoad || DecMemWr);

   seq_mem_wait #(
      .MEM_LAT (MEM_LAT)
   ) u_mem_wait (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .load   (mem_load),
      .en     (state_reg == MEM),
      .expire (mem_expire)
   );

`ifdef SEQ_WATCHDOG_EN
   logic timeout_reg;
   assign wdog_fire = busy_reg && (cycle_reg == (WDOG_LIMIT - kCntOne));
`else
   assign wdog_fire = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg   <= IDLE;
         irload_reg  <= 1'b0;
         pcen_reg    <= 1'b0;
         regwr_reg   <= 1'b0;
         memwr_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         cycle_reg   <= '0;
         inst_reg    <= '0;
`ifdef SEQ_WATCHDOG_EN
         timeout_reg <= 1'b0;
`endif
      end else begin
         irload_reg <= 1'b0;
         pcen_reg   <= 1'b0;
         regwr_reg  <= 1'b0;
         memwr_reg  <= 1'b0;
         if (busy_reg) begin
            cycle_reg <= sat_inc(cycle_reg);
         end

         case (state_reg)
            IDLE, HALT: begin
               if (Start) begin
                  // The Start cycle itself is the first cycle of the run.
                  state_reg  <= FETCH;
                  irload_reg <= 1'b1;
                  busy_reg   <= 1'b1;
                  done_reg   <= 1'b0;
                  cycle_reg  <= kCntOne;
                  inst_reg   <= '0;
               end
            end
            FETCH: begin
               state_reg <= EXEC;
            end
            EXEC: begin
               if (DecAck) begin
                  state_reg <= HALT;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  inst_reg  <= sat_inc(inst_reg);
               end else if (DecLoad || DecMemWr) begin
                  state_reg <= MEM;
                  memwr_reg <= DecMemWr;
               end else begin
                  state_reg <= WB;
                  regwr_reg <= DecRegWr;
                  pcen_reg  <= 1'b1;
               end
            end
            MEM: begin
               if (mem_expire) begin
                  state_reg <= WB;
                  regwr_reg <= DecRegWr;
                  pcen_reg  <= 1'b1;
               end
            end
            WB: begin
               state_reg  <= FETCH;
               irload_reg <= 1'b1;
               inst_reg   <= sat_inc(inst_reg);
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase

`ifdef SEQ_WATCHDOG_EN
         // Forced halt overrides whatever the instruction was about to do.
         if (wdog_fire) begin
            state_reg   <= HALT;
            irload_reg  <= 1'b0;
            pcen_reg    <= 1'b0;
            regwr_reg   <= 1'b0;
            memwr_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            timeout_reg <= 1'b1;
            inst_reg    <= inst_reg;
         end else if (start_ok) begin
            timeout_reg <= 1'b0;
         end
`endif
      end
   end

   assign PCReset    = Reset_n && start_ok;
   assign IrLoad     = irload_reg;
   assign PCEn       = pcen_reg  && !wdog_fire;
   assign RegWrEn    = regwr_reg && !wdog_fire;
   assign MemWrEn    = memwr_reg && !wdog_fire;
   assign Busy       = busy_reg;
   assign Done       = done_reg;
   assign CycleCount = cycle_reg;
   assign InstCount  = inst_reg;
`ifdef SEQ_WATCHDOG_EN
   assign Timeout    = timeout_reg;
`else
   assign Timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Directed scoreboard bench for run_sequencer: two instances (MEM_LAT 1 and 3) driven by a tiny core model.
// Watchdog expectations follow SEQ_WATCHDOG_EN.
module tb_run_sequencer;

   localparam int CW    = 16;
   localparam int K_ALU = 0;   // ALU op that writes a register
   localparam int K_BR  = 1;   // branch / no register write
   localparam int K_LD  = 2;
   localparam int K_ST  = 3;
   localparam int K_ACK = 4;

   typedef struct packed {
      logic [2:0]  code;
      logic [15:0] cyc;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic [1:0] start_s;
   logic [1:0] dec_regwr, dec_memwr, dec_load, dec_ack;
   logic [1:0] pcreset_w, pcen_w, irload_w, regwr_w, memwr_w, busy_w, done_w, timeout_w;
   logic [1:0][CW-1:0] cyc_w, inst_w;

   int prog [2][32];
   ev_t exp_q [$];
   int total = 0;
   int bad   = 0;
   int exp_inst, exp_cyc;
   bit exp_done, exp_tmo;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      int pc_q;
      int ir_q;

      run_sequencer #(
         .MEM_LAT ((gi == 0) ? 1 : 3)
`ifdef SEQ_WATCHDOG_EN
         ,
         .WDOG_LIMIT (16'd20)
`endif
      ) u_dut (
         .Clk        (clk),
         .Reset_n    (rst_n),
         .Start      (start_s[gi]),
         .DecRegWr   (dec_regwr[gi]),
         .DecMemWr   (dec_memwr[gi]),
         .DecLoad    (dec_load[gi]),
         .DecAck     (dec_ack[gi]),
         .PCReset    (pcreset_w[gi]),
         .PCEn       (pcen_w[gi]),
         .IrLoad     (irload_w[gi]),
         .RegWrEn    (regwr_w[gi]),
         .MemWrEn    (memwr_w[gi]),
         .Busy       (busy_w[gi]),
         .Done       (done_w[gi]),
         .Timeout    (timeout_w[gi]),
         .CycleCount (cyc_w[gi]),
         .InstCount  (inst_w[gi])
      );

      // Minimal PC / instruction register / decoder around the sequencer.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pc_q <= 0;
            ir_q <= K_BR;
         end else begin
            if (pcreset_w[gi])   pc_q <= 0;
            else if (pcen_w[gi]) pc_q <= pc_q + 1;
            if (irload_w[gi])    ir_q <= prog[gi][pc_q & 31];
         end
      end

      assign dec_regwr[gi] = (ir_q == K_ALU) || (ir_q == K_LD);
      assign dec_memwr[gi] = (ir_q == K_ST);
      assign dec_load[gi]  = (ir_q == K_LD);
      assign dec_ack[gi]   = (ir_q == K_ACK);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic fill_prog(input int d, input int fill);
      for (int i = 0; i < 32; i++) prog[d][i] = fill;
   endtask

   task automatic push_ev(input int code, input int c, input int maxcyc);
      ev_t e;
      if (c <= maxcyc) begin
         e.code = 3'(code);
         e.cyc  = 16'(c);
         exp_q.push_back(e);
      end
   endtask

   // Reference timing: ALU 3 cycles, load/store 3+lat, first IrLoad one cycle after Start.
   task automatic build_expect(input int d, input int lat, input int limit, input int maxcyc);
      int t, pc, k, w, wd, lim;
      bit fin;
      exp_q.delete();
      exp_inst = 0; exp_done = 0; exp_tmo = 0; exp_cyc = maxcyc;
      wd  = (limit > 0) ? limit - 1 : (1 << 30);
      lim = (wd < maxcyc) ? wd : maxcyc;
      t = 1; pc = 0; fin = 0;
      while (!fin) begin
         if (t > wd) begin
            exp_done = 1; exp_tmo = 1; exp_cyc = limit;
            push_ev(4, limit, maxcyc);
            fin = 1;
         end else if (t > maxcyc) begin
            fin = 1;
         end else begin
            k = prog[d][pc & 31];
            push_ev(0, t, maxcyc);
            if (k == K_ACK) begin
               if (t + 1 < lim) begin
                  exp_inst++; exp_done = 1; exp_cyc = t + 2;
                  push_ev(4, t + 2, maxcyc);
                  fin = 1;
               end else begin
                  t = t + 2;
               end
            end else begin
               w = ((k == K_LD) || (k == K_ST)) ? t + 2 + lat : t + 2;
               if ((k == K_ST) && (t + 2 < wd)) push_ev(3, t + 2, maxcyc);
               if (w < wd) begin
                  push_ev(1, w, maxcyc);
                  if ((k == K_ALU) || (k == K_LD)) push_ev(2, w, maxcyc);
               end
               if (w < lim) exp_inst++;
               pc++;
               t = w + 1;
            end
         end
      end
   endtask

   task automatic run_prog(input int d, input bit hold, input int maxcyc);
      string names [5] = '{"irload", "pcen", "regwr", "memwr", "done"};
      logic [4:0] sig;
      ev_t got, ev;
      bit stop;
      int spurious;
      @(negedge clk);
      start_s[d] = 1'b1;
      #1 check("pcreset_c0", 32'(pcreset_w[d]), 32'd1);
      stop = 0;
      spurious = 0;
      for (int k = 1; (k <= maxcyc) && !stop; k++) begin
         @(negedge clk);
         if (!hold) start_s[d] = 1'b0;
         sig = {done_w[d], memwr_w[d], regwr_w[d], pcen_w[d], irload_w[d]};
         if (busy_w[d] && pcreset_w[d]) spurious++;
         for (int c = 0; c < 5; c++) begin
            if (sig[c]) begin
               got.code = 3'(c);
               got.cyc  = 16'(k);
               if (exp_q.size() > 0) ev = exp_q.pop_front();
               else begin ev.code = 3'd7; ev.cyc = '0; end
               check(names[c], 32'(got), 32'(ev));
               $display("d%0d cyc %0d %s", d, k, names[c]);
            end
         end
         if (done_w[d]) stop = 1;
      end
      check("missing_events", exp_q.size(), 32'd0);
      check("pcreset_while_busy", spurious, 32'd0);
   endtask

   task automatic post_checks(input int d);
      check("done",     32'(done_w[d]),    32'(exp_done));
      check("busy",     32'(busy_w[d]),    32'(!exp_done));
      check("timeout",  32'(timeout_w[d]), 32'(exp_tmo));
      check("instcnt",  32'(inst_w[d]),    32'(exp_inst));
      check("cyclecnt", 32'(cyc_w[d]),     32'(exp_cyc));
   endtask

   initial begin
      rst_n   = 1'b0;
      start_s = 2'b11;
      fill_prog(0, K_BR);
      fill_prog(1, K_BR);
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_pcreset", 32'(pcreset_w[d]), 32'd0);
         check("rst_busy",    32'(busy_w[d]),    32'd0);
         check("rst_done",    32'(done_w[d]),    32'd0);
         check("rst_strobes", 32'({irload_w[d], pcen_w[d], regwr_w[d], memwr_w[d], timeout_w[d]}), 32'd0);
         check("rst_counts",  32'({cyc_w[d], inst_w[d]}), 32'd0);
      end
      start_s = 2'b00;
      rst_n   = 1'b1;

      // ALU then Ack on MEM_LAT=1.
      prog[0][0] = K_ALU; prog[0][1] = K_ACK;
      build_expect(0, 1, 0, 40);
      check("model_alu_ack_cycles", 32'(exp_cyc), 32'd6);
      run_prog(0, 1'b0, 40);
      post_checks(0);
      @(negedge clk);
      check("done_held", 32'(done_w[0]), 32'd1);
      check("cycle_frozen", 32'(cyc_w[0]), 32'(exp_cyc));

      // Store with MEM_LAT=3: one MemWrEn pulse, six-cycle instruction.
      fill_prog(1, K_BR);
      prog[1][0] = K_ST; prog[1][1] = K_ACK;
      build_expect(1, 3, 0, 40);
      run_prog(1, 1'b0, 40);
      post_checks(1);

      // Load with MEM_LAT=1, restarted from HALT.
      fill_prog(0, K_BR);
      prog[0][0] = K_LD; prog[0][1] = K_BR; prog[0][2] = K_ACK;
      build_expect(0, 1, 0, 40);
      run_prog(0, 1'b0, 40);
      post_checks(0);

      // Start held for the whole run: ignored while busy, restarts from HALT.
      fill_prog(0, K_BR);
      prog[0][0] = K_ALU; prog[0][1] = K_LD; prog[0][2] = K_ACK;
      build_expect(0, 1, 0, 40);
      run_prog(0, 1'b1, 40);
      post_checks(0);
      check("halt_restart_pcreset", 32'(pcreset_w[0]), 32'd1);
      @(negedge clk);
      start_s[0] = 1'b0;
      check("restart_done_drop", 32'(done_w[0]),   32'd0);
      check("restart_busy",      32'(busy_w[0]),   32'd1);
      check("restart_irload",    32'(irload_w[0]), 32'd1);
      check("restart_counts",    32'({cyc_w[0], inst_w[0]}), {16'd1, 16'd0});

      // Asynchronous reset in the middle of a register-writing WB.
      @(negedge clk);
      @(negedge clk);
      check("wb_regwr_before_reset", 32'(regwr_w[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_regwr_drop", 32'(regwr_w[0]), 32'd0);
      check("async_pcen_drop",  32'(pcen_w[0]),  32'd0);
      check("async_busy",       32'(busy_w[0]),  32'd0);
      check("async_counts",     32'({cyc_w[0], inst_w[0]}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Program with no Ack: watchdog halt, or free running without it.
      fill_prog(0, K_ALU);
      prog[0][0] = K_ST;
`ifdef SEQ_WATCHDOG_EN
      build_expect(0, 1, 20, 60);
      run_prog(0, 1'b0, 60);
`else
      build_expect(0, 1, 0, 30);
      run_prog(0, 1'b0, 30);
`endif
      post_checks(0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
